// File: rtl/filter_frame_writer.sv
// Frame-buffer writer for the RGB filter output: turns (x, y) pixel coordinates into
// linear addresses and queues address/data pairs in a FWFT FIFO drained by a valid/ready port.
module filter_frame_writer #(
    parameter  int BITWIDTH = 8,
    parameter  int COLS     = 640,
    parameter  int ROWS     = 480,
    parameter  int DEPTH    = 16,
    localparam int XW       = $clog2(COLS) + 1,
    localparam int YW       = $clog2(ROWS) + 1,
    localparam int AW       = $clog2(COLS * ROWS),
    localparam int LW       = $clog2(DEPTH) + 1,
    localparam int PIXW     = 3 * BITWIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            process_enable,
    input  logic            pix_valid,
    input  logic [PIXW-1:0] pix_data,
    input  logic [XW-1:0]   pix_x,
    input  logic [YW-1:0]   pix_y,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [AW-1:0]   mem_addr,
    output logic [PIXW-1:0] mem_data,
    output logic            frame_done,
    output logic            overflow,
    input  logic            clr_flags,
    output logic [LW-1:0]   fifo_level
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [XW-1:0] COLS_X    = XW'(COLS);
    localparam logic [YW-1:0] ROWS_Y    = YW'(ROWS);
    localparam logic [AW-1:0] COLS_A    = AW'(COLS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(COLS * ROWS - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

    typedef struct packed {
        logic            last;
        logic [AW-1:0]   addr;
        logic [PIXW-1:0] data;
    } entry_t;

    entry_t          store [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    entry_t          head;

    logic            accept;
    logic            full;
    logic            push;
    logic            pop;
    logic            drop;
    logic [AW-1:0]   addr_in;
    entry_t          entry_in;
    logic [PW-1:0]   rd_ptr_next;
    logic [LW-1:0]   level_next;
    entry_t          head_next;

    // Coordinates are only multiplied once they are known to be in range, so the
    // narrowing casts to AW never lose information.
    always_comb begin
        accept   = process_enable & pix_valid & (pix_x < COLS_X) & (pix_y < ROWS_Y);
        addr_in  = AW'(pix_y) * COLS_A + AW'(pix_x);
        entry_in = '{last: (addr_in == LAST_ADDR), addr: addr_in, data: pix_data};
    end

    assign full       = (level == FULL_LVL);
    assign mem_valid  = (level != '0);
    assign pop        = mem_valid & mem_ready;
    assign push       = accept & (~full | pop);
    assign drop       = accept & full & ~pop;
    assign fifo_level = level;
    assign mem_addr   = head.addr;
    assign mem_data   = head.data;

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    // The head register mirrors the entry at the read pointer after this edge. When the
    // incoming pixel becomes the only entry it bypasses the storage array; when the queue
    // empties the head is held so the port keeps showing the last written pixel.
    always_comb begin
        rd_ptr_next = rd_ptr + PW'(pop);
        head_next   = head;
        if (push && (level == LW'(pop))) begin
            head_next = entry_in;
        end else if (level_next != '0) begin
            head_next = store[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= entry_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head       <= '0;
            frame_done <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr     <= rd_ptr_next;
            level      <= level_next;
            head       <= head_next;
            frame_done <= pop & head.last;
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_flags) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_filter_frame_writer.sv
// Directed bench for filter_frame_writer on a 4x2 frame with a 4-entry FIFO.
module tb_filter_frame_writer;

    localparam int BITWIDTH = 8;
    localparam int COLS     = 4;
    localparam int ROWS     = 2;
    localparam int DEPTH    = 4;
    localparam int XW       = $clog2(COLS) + 1;
    localparam int YW       = $clog2(ROWS) + 1;
    localparam int AW       = $clog2(COLS * ROWS);
    localparam int LW       = $clog2(DEPTH) + 1;
    localparam int PIXW     = 3 * BITWIDTH;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            process_enable = 1'b1;
    logic            pix_valid = 1'b0;
    logic [PIXW-1:0] pix_data = '0;
    logic [XW-1:0]   pix_x = '0;
    logic [YW-1:0]   pix_y = '0;
    logic            mem_valid;
    logic            mem_ready = 1'b0;
    logic [AW-1:0]   mem_addr;
    logic [PIXW-1:0] mem_data;
    logic            frame_done;
    logic            overflow;
    logic            clr_flags = 1'b0;
    logic [LW-1:0]   fifo_level;

    int test_count = 0;
    int fail_count = 0;

    filter_frame_writer #(
        .BITWIDTH(BITWIDTH),
        .COLS    (COLS),
        .ROWS    (ROWS),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .process_enable(process_enable),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .frame_done    (frame_done),
        .overflow      (overflow),
        .clr_flags     (clr_flags),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input int x, input int y, input logic [PIXW-1:0] data);
        pix_valid = valid;
        pix_x     = XW'(x);
        pix_y     = YW'(y);
        pix_data  = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_addr [4];

        // Reset state
        #2;
        checkOutput("reset mem_valid", 32'(mem_valid), 32'd0);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset mem_data", 32'(mem_data), 32'd0);
        checkOutput("reset fifo_level", 32'(fifo_level), 32'd0);
        checkOutput("reset frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Single pixel at (2,1) lands at address 6
        mem_ready = 1'b1;
        applyStimulus(1'b1, 2, 1, 24'h112233);
        step();
        applyStimulus(1'b0, 0, 0, 24'h0);
        checkOutput("t1 mem_valid", 32'(mem_valid), 32'd1);
        checkOutput("t1 mem_addr", 32'(mem_addr), 32'd6);
        checkOutput("t1 mem_data", 32'(mem_data), 32'h112233);
        checkOutput("t1 level1", 32'(fifo_level), 32'd1);
        step();
        checkOutput("t1 level0", 32'(fifo_level), 32'd0);
        checkOutput("t1 drained", 32'(mem_valid), 32'd0);
        checkOutput("t1 addr held", 32'(mem_addr), 32'd6);
        checkOutput("t1 frame_done", 32'(frame_done), 32'd0);

        // Full frame in raster order
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, i % 4, i / 4, 24'h100000 + 24'(i));
            step();
            checkOutput($sformatf("t2 addr%0d", i), 32'(mem_addr), 32'(i));
            checkOutput($sformatf("t2 data%0d", i), 32'(mem_data), 32'h100000 + 32'(i));
            checkOutput($sformatf("t2 level%0d", i), 32'(fifo_level), 32'd1);
            checkOutput($sformatf("t2 no done%0d", i), 32'(frame_done), 32'd0);
        end
        applyStimulus(1'b0, 0, 0, 24'h0);
        step();
        checkOutput("t2 frame_done pulse", 32'(frame_done), 32'd1);
        checkOutput("t2 empty", 32'(mem_valid), 32'd0);
        step();
        checkOutput("t2 frame_done low", 32'(frame_done), 32'd0);
        checkOutput("t2 overflow", 32'(overflow), 32'd0);

        // Back-pressure: fill, drop the fifth pixel, then drain in order
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, i % 4, i / 4, 24'hA0 + 24'(i));
            step();
            checkOutput($sformatf("t3 level%0d", i), 32'(fifo_level), (i < 4) ? 32'(i + 1) : 32'd4);
            checkOutput($sformatf("t3 head addr%0d", i), 32'(mem_addr), 32'd0);
            checkOutput($sformatf("t3 head data%0d", i), 32'(mem_data), 32'hA0);
        end
        applyStimulus(1'b0, 0, 0, 24'h0);
        checkOutput("t3 overflow", 32'(overflow), 32'd1);
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t3 drain valid%0d", k), 32'(mem_valid), 32'd1);
            checkOutput($sformatf("t3 drain addr%0d", k), 32'(mem_addr), 32'(k));
            checkOutput($sformatf("t3 drain data%0d", k), 32'(mem_data), 32'hA0 + 32'(k));
            step();
        end
        checkOutput("t3 drained", 32'(mem_valid), 32'd0);
        checkOutput("t3 level", 32'(fifo_level), 32'd0);
        checkOutput("t3 overflow sticky", 32'(overflow), 32'd1);

        // Clearing the sticky overflow flag
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        checkOutput("t5 clr overflow", 32'(overflow), 32'd0);

        // Full FIFO accepting a pixel while writing one
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, i, 0, 24'hB0 + 24'(i));
            step();
        end
        checkOutput("t4 full level", 32'(fifo_level), 32'd4);
        checkOutput("t4 head before", 32'(mem_addr), 32'd0);
        mem_ready = 1'b1;
        applyStimulus(1'b1, 1, 1, 24'hB5);
        step();
        applyStimulus(1'b0, 0, 0, 24'h0);
        checkOutput("t4 level kept", 32'(fifo_level), 32'd4);
        checkOutput("t4 no overflow", 32'(overflow), 32'd0);
        exp_addr = '{1, 2, 3, 5};
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t4 order addr%0d", k), 32'(mem_addr), 32'(exp_addr[k]));
            checkOutput($sformatf("t4 order data%0d", k), 32'(mem_data), 32'hB0 + 32'(exp_addr[k] == 5 ? 5 : exp_addr[k]));
            step();
        end
        checkOutput("t4 drained", 32'(fifo_level), 32'd0);

        // Out-of-range coordinates and disabled pipeline are ignored
        applyStimulus(1'b1, 4, 0, 24'hCC);
        step();
        checkOutput("t5 x range level", 32'(fifo_level), 32'd0);
        checkOutput("t5 x range overflow", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 0, 2, 24'hCD);
        step();
        checkOutput("t5 y range level", 32'(fifo_level), 32'd0);
        process_enable = 1'b0;
        applyStimulus(1'b1, 1, 0, 24'hCE);
        step();
        checkOutput("t5 disabled level", 32'(fifo_level), 32'd0);
        checkOutput("t5 disabled valid", 32'(mem_valid), 32'd0);
        process_enable = 1'b1;

        // Reset while entries (including the last pixel) are queued
        mem_ready = 1'b0;
        for (int i = 5; i < 8; i++) begin
            applyStimulus(1'b1, i % 4, i / 4, 24'hD0 + 24'(i));
            step();
        end
        applyStimulus(1'b0, 0, 0, 24'h0);
        checkOutput("t6 queued", 32'(fifo_level), 32'd3);
        checkOutput("t6 head", 32'(mem_addr), 32'd5);
        rst = 1'b1;
        #1;
        checkOutput("t6 async valid", 32'(mem_valid), 32'd0);
        checkOutput("t6 async addr", 32'(mem_addr), 32'd0);
        checkOutput("t6 async data", 32'(mem_data), 32'd0);
        checkOutput("t6 async level", 32'(fifo_level), 32'd0);
        step();
        rst = 1'b0;
        mem_ready = 1'b1;
        step();
        checkOutput("t6 post level", 32'(fifo_level), 32'd0);
        checkOutput("t6 post valid", 32'(mem_valid), 32'd0);
        checkOutput("t6 post done", 32'(frame_done), 32'd0);
        step();
        checkOutput("t6 post done2", 32'(frame_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
